clk_div_bank: RTL and testbench

- Parametrised bank of NUM_CH independent clock-enable/tick generators. All run from the 100 MHz system clock.
- Successor to the fixed 25 MHz / 60 Hz / 5 Hz divider. Divisors are runtime-reprogrammable through a valid/ready config port. Each channel can be a toggle square wave or a single-cycle tick.
- Updates are glitch-free and applied at terminal count. A global restart phase-aligns all channels.
- Feeds the VGA controller, frame/game-logic timing and the slow animation timer.

---
 rtl/clk_div_pkg.sv | 42 ++++
 rtl/clk_div_ch.sv | 166 ++++++++++++++++
 rtl/clk_div_bank.sv | 63 ++++++
 tb/tb_clk_div_bank.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and reset defaults for the clock-enable divider bank.
// CLK_DIV_PHASE_EN adds a per-channel start phase to the configuration.
package clk_div_pkg;

    localparam int   CNT_W_DEF   = 24;
    localparam int   NUM_DEF_CH  = 3;
    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_TICK   = 1'b1;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } ch_state_e;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] div;
        logic                 mode;
`ifdef CLK_DIV_PHASE_EN
        logic [CNT_W_DEF-1:0] phase;
`endif
    } ch_cfg_t;

    // 25 MHz enable, 60 Hz and 5 Hz squares from the 100 MHz system clock
    localparam logic [NUM_DEF_CH-1:0][CNT_W_DEF-1:0] DEF_DIV =
        {24'd10_000_000, 24'd833_333, 24'd4};
    localparam logic [NUM_DEF_CH-1:0] DEF_MODE = {MODE_TOGGLE, MODE_TOGGLE, MODE_TICK};

    function automatic ch_cfg_t def_cfg(input int ch);
        ch_cfg_t c;
        c = '0;
        if (ch < NUM_DEF_CH) begin
            c.div  = DEF_DIV[ch[1:0]];
            c.mode = DEF_MODE[ch[1:0]];
        end else begin
            c.div  = 24'd1;
            c.mode = MODE_TICK;
        end
        return c;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, OFF/RUN/PEND sequencing and shadow config.
// CLK_DIV_PHASE_EN: counters start from a clamped programmable phase.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int               CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEF_DIV  = 1,
    parameter logic             DEF_MODE = MODE_TICK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic             en,
    input  logic             acc,
    input  logic [CNT_W-1:0] acc_div,
    input  logic             acc_mode,
`ifdef CLK_DIV_PHASE_EN
    input  logic [CNT_W-1:0] acc_phase,
`endif
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    ch_state_e        state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [CNT_W-1:0] div_r, div_s, sh_div_r, sh_div_s;
    logic             mode_r, mode_s, sh_mode_r, sh_mode_s;
    logic             clk_out_r, clk_out_s, tick_r, tick_s;
    logic [CNT_W-1:0] div_eff_s, nxt_eff_s, start_s;
    logic             tc_s, direct_s, apply_sh_s;
`ifdef CLK_DIV_PHASE_EN
    logic [CNT_W-1:0] phase_r, phase_s, sh_phase_r, sh_phase_s;
`endif

    // Live/shadow configuration selection and start value of the counter
    always_comb begin
        div_eff_s  = (div_r == '0) ? CNT_W'(1) : div_r;
        tc_s       = (state_r != OFF) && (cnt_r == div_eff_s - CNT_W'(1));
        // Outside a running period a write goes straight to the live registers
        direct_s   = acc && (restart || !en || (state_r == OFF));
        apply_sh_s = (state_r == PEND) && (restart || !en || tc_s);
        sh_div_s   = sh_div_r;
        sh_mode_s  = sh_mode_r;
        div_s      = div_r;
        mode_s     = mode_r;
`ifdef CLK_DIV_PHASE_EN
        sh_phase_s = sh_phase_r;
        phase_s    = phase_r;
`endif
        if (acc && !direct_s) begin
            sh_div_s  = acc_div;
            sh_mode_s = acc_mode;
`ifdef CLK_DIV_PHASE_EN
            sh_phase_s = acc_phase;
`endif
        end else begin
            sh_div_s = sh_div_r;
        end
        if (direct_s) begin
            div_s  = acc_div;
            mode_s = acc_mode;
`ifdef CLK_DIV_PHASE_EN
            phase_s = acc_phase;
`endif
        end else if (apply_sh_s) begin
            div_s  = sh_div_r;
            mode_s = sh_mode_r;
`ifdef CLK_DIV_PHASE_EN
            phase_s = sh_phase_r;
`endif
        end else begin
            div_s = div_r;
        end
        nxt_eff_s = (div_s == '0) ? CNT_W'(1) : div_s;
`ifdef CLK_DIV_PHASE_EN
        start_s = (phase_s > nxt_eff_s - CNT_W'(1)) ? nxt_eff_s - CNT_W'(1) : phase_s;
`else
        start_s = '0;
`endif
    end

    // Channel FSM next state, counter and output levels
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        clk_out_s = clk_out_r;
        tick_s    = 1'b0;
        if (restart) begin
            state_s   = en ? RUN : OFF;
            cnt_s     = en ? start_s : '0;
            clk_out_s = 1'b0;
        end else if (!en) begin
            state_s   = OFF;
            cnt_s     = '0;
            clk_out_s = 1'b0;
        end else begin
            case (state_r)
                OFF: begin
                    state_s   = RUN;
                    cnt_s     = start_s;
                    clk_out_s = 1'b0;
                end
                RUN, PEND: begin
                    if (tc_s) begin
                        cnt_s  = '0;
                        tick_s = 1'b1;
                        if (apply_sh_s && (sh_mode_r != mode_r)) begin
                            clk_out_s = 1'b0;
                        end else if (mode_r == MODE_TICK) begin
                            clk_out_s = 1'b1;
                        end else begin
                            clk_out_s = !clk_out_r;
                        end
                        state_s = acc ? PEND : RUN;
                    end else begin
                        cnt_s     = cnt_r + CNT_W'(1);
                        clk_out_s = (mode_r == MODE_TICK) ? 1'b0 : clk_out_r;
                        state_s   = acc ? PEND : state_r;
                    end
                end
                default: begin
                    state_s   = OFF;
                    cnt_s     = '0;
                    clk_out_s = 1'b0;
                end
            endcase
        end
    end

    // State, counter, configuration and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= OFF;
            cnt_r     <= '0;
            div_r     <= DEF_DIV;
            mode_r    <= DEF_MODE;
            sh_div_r  <= DEF_DIV;
            sh_mode_r <= DEF_MODE;
            clk_out_r <= 1'b0;
            tick_r    <= 1'b0;
`ifdef CLK_DIV_PHASE_EN
            phase_r    <= '0;
            sh_phase_r <= '0;
`endif
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            div_r     <= div_s;
            mode_r    <= mode_s;
            sh_div_r  <= sh_div_s;
            sh_mode_r <= sh_mode_s;
            clk_out_r <= clk_out_s;
            tick_r    <= tick_s;
`ifdef CLK_DIV_PHASE_EN
            phase_r    <= phase_s;
            sh_phase_r <= sh_phase_s;
`endif
        end
    end

    assign pending = (state_r == PEND);
    assign clk_out = clk_out_r;
    assign tick    = tick_r;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH clock-enable/tick generators with a valid/ready config port.
// Define CLK_DIV_PHASE_EN to add the cfg_phase input for phase offsets.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_100MHz,
    input  logic              reset_n,
    input  logic              restart,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
`ifdef CLK_DIV_PHASE_EN
    input  logic [CNT_W-1:0]  cfg_phase,
`endif
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0]      pending_s;
    logic [(1<<CH_W)-1:0]   pend_ext_s;
    logic                   acc_s;

    // Out-of-range channel numbers see a never-pending slot and are ready
    always_comb begin
        pend_ext_s               = '0;
        pend_ext_s[NUM_CH-1:0]   = pending_s;
        cfg_ready                = !pend_ext_s[cfg_ch];
    end

    assign acc_s = cfg_valid && cfg_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam ch_cfg_t DEF = def_cfg(i);

        clk_div_ch #(
            .CNT_W    (CNT_W),
            .DEF_DIV  (CNT_W'(DEF.div)),
            .DEF_MODE (DEF.mode)
        ) u_ch (
            .clk      (clk_100MHz),
            .rst_n    (reset_n),
            .restart  (restart),
            .en       (ch_en[i]),
            .acc      (acc_s && (cfg_ch == CH_W'(i))),
            .acc_div  (cfg_div),
            .acc_mode (cfg_mode),
`ifdef CLK_DIV_PHASE_EN
            .acc_phase(cfg_phase),
`endif
            .pending  (pending_s[i]),
            .clk_out  (clk_out[i]),
            .tick     (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: an event-time reference model predicts
// tick/clk_out/cfg_ready each cycle; a negedge monitor compares.
module tb_clk_div_bank;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 24;
    localparam int CH_W   = 2;

    logic              clk_100MHz = 1'b0;
    logic              reset_n    = 1'b0;
    logic              restart    = 1'b0;
    logic [NUM_CH-1:0] ch_en      = '0;
    logic              cfg_valid  = 1'b0;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch     = '0;
    logic [CNT_W-1:0]  cfg_div    = '0;
    logic              cfg_mode   = 1'b0;
    logic [CNT_W-1:0]  cfg_phase  = '0;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    int errors = 0;
    int checks = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    clk_div_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
        .clk_100MHz(clk_100MHz),
        .reset_n   (reset_n),
        .restart   (restart),
        .ch_en     (ch_en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_mode  (cfg_mode),
`ifdef CLK_DIV_PHASE_EN
        .cfg_phase (cfg_phase),
`endif
        .clk_out   (clk_out),
        .tick      (tick)
    );

    // Reference model: each channel is described by the absolute edge number
    // of its next tick rather than by a counter.
    longint n = 0;
    bit     m_on[4], m_pend[4], m_lvl[4], m_tk[4], m_mode[4], s_mode[4];
    longint m_div[4], s_div[4], m_ph[4], s_ph[4], due[4];

    typedef struct packed {
        logic [NUM_CH-1:0] tk;
        logic [NUM_CH-1:0] co;
        logic              rdy;
    } exp_t;
    exp_t q[$];

    function automatic longint deff(input longint d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic longint start_of(input int c);
`ifdef CLK_DIV_PHASE_EN
        return (m_ph[c] > deff(m_div[c]) - 1) ? deff(m_div[c]) - 1 : m_ph[c];
`else
        return (m_ph[c] < 0) ? m_ph[c] : 0;
`endif
    endfunction

    task automatic model_edge();
        bit acc, a;
        acc = cfg_valid && !m_pend[cfg_ch];
        n++;
        for (int c = 0; c < NUM_CH; c++) begin
            a = acc && (int'(cfg_ch) == c);
            if (restart || !ch_en[c] || !m_on[c]) begin
                if (m_pend[c]) begin
                    m_div[c] = s_div[c]; m_mode[c] = s_mode[c]; m_ph[c] = s_ph[c];
                end
                if (a) begin
                    m_div[c] = cfg_div; m_mode[c] = cfg_mode; m_ph[c] = cfg_phase;
                end
                m_pend[c] = 0; m_lvl[c] = 0; m_tk[c] = 0;
                m_on[c] = ch_en[c];
                if (ch_en[c]) due[c] = n + deff(m_div[c]) - start_of(c);
            end else begin
                m_tk[c] = (n == due[c]);
                if (m_tk[c]) begin
                    if (m_pend[c] && (s_mode[c] != m_mode[c])) m_lvl[c] = 0;
                    else m_lvl[c] = m_mode[c] ? 1'b1 : !m_lvl[c];
                    if (m_pend[c]) begin
                        m_div[c] = s_div[c]; m_mode[c] = s_mode[c]; m_ph[c] = s_ph[c];
                        m_pend[c] = 0;
                    end
                    due[c] = n + deff(m_div[c]);
                end else if (m_mode[c]) begin
                    m_lvl[c] = 0;
                end
                if (a) begin
                    s_div[c] = cfg_div; s_mode[c] = cfg_mode; s_ph[c] = cfg_phase;
                    m_pend[c] = 1;
                end
            end
        end
    endtask

    // One clock: model the edge, then drive the inputs for the next edge
    task automatic cycle(input bit rs, input logic [NUM_CH-1:0] en, input bit v,
                         input int ch, input int dv, input bit md, input int ph);
        exp_t e;
        @(posedge clk_100MHz);
        model_edge();
        #1;
        restart   = rs;
        ch_en     = en;
        cfg_valid = v;
        cfg_ch    = CH_W'(ch);
        cfg_div   = CNT_W'(dv);
        cfg_mode  = md;
        cfg_phase = CNT_W'(ph);
        for (int c = 0; c < NUM_CH; c++) begin
            e.tk[c] = m_tk[c];
            e.co[c] = m_lvl[c];
        end
        e.rdy = !m_pend[cfg_ch];
        q.push_back(e);
    endtask

    task automatic idle(input int cycles, input logic [NUM_CH-1:0] en);
        for (int k = 0; k < cycles; k++) cycle(0, en, 0, 0, 0, 0, 0);
    endtask

    // Monitor: pop one expectation per cycle and compare on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_100MHz);
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if ({tick, clk_out, cfg_ready} !== e) begin
                    errors++;
                    $display("FAIL outputs edge=%0d tick=%b clk_out=%b ready=%b required tick=%b clk_out=%b ready=%b",
                             n, tick, clk_out, cfg_ready, e.tk, e.co, e.rdy);
                end
            end
        end
    end

    initial begin
        logic [NUM_CH-1:0] cur_en;
        for (int c = 0; c < 4; c++) begin
            m_on[c] = 0; m_pend[c] = 0; m_lvl[c] = 0; m_tk[c] = 0;
            m_ph[c] = 0; s_ph[c] = 0; due[c] = 0; m_div[c] = 1; m_mode[c] = 1;
        end
        m_div[0] = 4;          m_mode[0] = 1;
        m_div[1] = 833_333;    m_mode[1] = 0;
        m_div[2] = 10_000_000; m_mode[2] = 0;
        for (int c = 0; c < 4; c++) begin
            s_div[c] = m_div[c]; s_mode[c] = m_mode[c];
        end

        repeat (3) @(negedge clk_100MHz);
        checks++;
        if ({tick, clk_out, cfg_ready} !== {3'b000, 3'b000, 1'b1}) begin
            errors++;
            $display("FAIL reset_state tick=%b clk_out=%b ready=%b required 000 000 1",
                     tick, clk_out, cfg_ready);
        end
        reset_n = 1'b1;

        // Defaults: ch0 ticks every 4 cycles
        cycle(0, 3'b111, 0, 0, 0, 0, 0);
        idle(40, 3'b111);
        // ch1 div 5 toggle goes pending; a second write to ch1 stalls
        cycle(0, 3'b111, 1, 1, 5, 0, 0);
        for (int k = 0; k < 6; k++) cycle(0, 3'b111, 1, 1, 7, 1, 0);
        cycle(0, 3'b111, 0, 1, 0, 0, 0);
        idle(3, 3'b111);
        // restart applies the pending ch1 write
        cycle(1, 3'b111, 0, 1, 0, 0, 0);
        idle(40, 3'b111);
        // ch0 div 3 and ch2 div 7, restart mid-count
        cycle(0, 3'b111, 1, 0, 3, 1, 0);
        cycle(0, 3'b111, 1, 2, 7, 1, 0);
        idle(4, 3'b111);
        cycle(1, 3'b111, 0, 0, 0, 0, 0);
        idle(20, 3'b111);
        // Mid-period reprogram of ch1 (toggle, div 3), then mode change to tick
        cycle(0, 3'b111, 1, 1, 3, 0, 0);
        idle(30, 3'b111);
        cycle(0, 3'b111, 1, 1, 4, 1, 0);
        idle(20, 3'b111);
        // div 0 and div 1 both tick every cycle
        cycle(0, 3'b111, 1, 0, 0, 1, 0);
        idle(12, 3'b111);
        cycle(0, 3'b111, 1, 0, 1, 1, 0);
        idle(12, 3'b111);
        // ch_en drop and re-enable on ch0 at div 4; out-of-range channel write
        cycle(0, 3'b111, 1, 0, 4, 1, 0);
        idle(10, 3'b111);
        idle(3, 3'b110);
        cycle(0, 3'b111, 1, 3, 2, 0, 0);
        idle(12, 3'b111);
`ifdef CLK_DIV_PHASE_EN
        // Phase offsets: 0 and 4 at div 8; phase 9 clamps to 7
        cycle(0, 3'b111, 1, 0, 8, 1, 0);
        cycle(0, 3'b111, 1, 1, 8, 1, 4);
        cycle(0, 3'b111, 1, 2, 8, 1, 9);
        idle(20, 3'b111);
        cycle(1, 3'b111, 0, 0, 0, 0, 0);
        idle(30, 3'b111);
`endif

        cur_en = 3'b111;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 31) == 0) cur_en[$urandom_range(0, 2)] ^= 1'b1;
            cycle(($urandom_range(0, 63) == 0), cur_en, ($urandom_range(0, 5) == 0),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, 14)));
        end

        repeat (2) @(negedge clk_100MHz);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
